// File: rtl/shift_seq.sv
// Sequential bit-serial shifter: shifts one bit per clock in logical, arithmetic, ones-fill or rotate mode.
// Rotate for mode 11 is present only when SHIFT_SEQ_ROTATE_EN is defined; otherwise mode 11 is logical.
module shift_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_work;
  logic [WIDTH-1:0]     w_work_next;
  logic [WIDTH-1:0]     w_shifted;
  logic [SHAMT_W-1:0]   r_cnt;
  logic                 r_dir;
  logic [1:0]           r_mode;
  logic                 r_sign;
  logic [WIDTH-1:0]     r_dout;
  logic                 w_fill;
  logic                 w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_fill = 1'b0;
    unique case (r_mode)
      2'b00: w_fill = 1'b0;
      2'b01: w_fill = r_dir ? 1'b0 : r_sign;
      2'b10: w_fill = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
      2'b11: w_fill = r_dir ? r_work[WIDTH-1] : r_work[0];
`else
      2'b11: w_fill = 1'b0;
`endif
      default: w_fill = 1'b0;
    endcase
  end

  assign w_shifted = r_dir ? {r_work[WIDTH-2:0], w_fill} : {w_fill, r_work[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = (shamt != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (r_cnt == SHAMT_W'(1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_work_next = r_work;
    if (w_accept)                 w_work_next = din;
    else if (r_state == S_SHIFT)  w_work_next = w_shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_mode <= 2'b00;
      r_sign <= 1'b0;
    end else begin
      r_work <= w_work_next;
      if (w_accept) begin
        r_cnt  <= shamt;
        r_dir  <= dir;
        r_mode <= mode;
        r_sign <= din[WIDTH-1];
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - SHAMT_W'(1);
      end
    end
  end

  // dout captures the value the working register takes on the edge that enters DONE,
  // so the final shift step (or the raw operand when shamt is 0) is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dout <= '0;
    else if (w_state_next == S_DONE && r_state != S_DONE) r_dout <= w_work_next;
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed vector table, corner sequences and random ops vs a model.
// Build with SHIFT_SEQ_ROTATE_EN defined on both files to check the rotate variant.
module tb_shift_seq;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               dir;
  logic [1:0]         mode;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;

  int checks = 0;
  int errors = 0;

  shift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .shamt(shamt),
    .dir(dir), .mode(mode), .busy(busy), .done(done), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-operation reference: result computed directly from amount and mode.
  function automatic logic [15:0] model(input logic [15:0] d, input int n, input logic l, input logic [1:0] m);
    logic [15:0] ones;
    logic [15:0] r;
    ones = 16'hFFFF;
    if (n == 0) return d;
    if (!l) begin
      case (m)
        2'b01:   r = $signed(d) >>> n;
        2'b10:   r = (d >> n) | ~(ones >> n);
`ifdef SHIFT_SEQ_ROTATE_EN
        2'b11:   r = (d >> n) | (d << (16 - n));
`endif
        default: r = d >> n;
      endcase
    end else begin
      case (m)
        2'b10:   r = (d << n) | (ones >> (16 - n));
`ifdef SHIFT_SEQ_ROTATE_EN
        2'b11:   r = (d << n) | (d >> (16 - n));
`endif
        default: r = d << n;
      endcase
    end
    return r;
  endfunction

  // Runs one op from IDLE. intrude>0 raises start with din=FFFF during that cycle after accept.
  task automatic run_op(input logic [15:0] d, input int n, input logic l, input logic [1:0] m,
                        input logic [15:0] exp, input int intrude, input string tag);
    int cyc;
    int bcnt;
    int lat;
    logic [15:0] res;
    @(negedge clk);
    rst_n = 1'b1;
    din = d; shamt = SHAMT_W'(n); dir = l; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din = 16'($urandom); shamt = SHAMT_W'($urandom); dir = 1'($urandom); mode = 2'($urandom);
    cyc = 1; bcnt = 0; lat = -1; res = 'x;
    while (cyc <= 40) begin
      if (intrude > 0 && cyc == intrude) begin start = 1'b1; din = 16'hFFFF; shamt = '0; end
      else if (intrude > 0 && cyc == intrude + 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin lat = cyc; res = dout; break; end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " dout"}, 32'(res), 32'(exp));
    check({tag, " latency"}, 32'(lat), 32'(n + 1));
    check({tag, " busy cycles"}, 32'(bcnt), 32'(n + 1));
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " idle after done"}, {30'd0, busy, done}, 32'd0);
    check({tag, " dout held"}, 32'(dout), 32'(exp));
    if (intrude > 0) begin
      @(posedge clk); #1;
      check({tag, " intrusion not accepted"}, 32'(busy), 32'd0);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    int          n;
    logic        l;
    logic [1:0]  m;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nodone;
    rst_n = 1'b0; start = 1'b0; din = '0; shamt = '0; dir = 1'b0; mode = 2'b00;
    #3;
    check("reset outputs", {14'd0, busy, done, dout}, 32'd0);
    repeat (2) @(posedge clk);

    vecs[0] = '{16'h8001, 1, 1'b0, 2'b10, 16'hC000};
    vecs[1] = '{16'h8000, 4, 1'b0, 2'b01, 16'hF800};
    vecs[2] = '{16'h00FF, 4, 1'b1, 2'b10, 16'h0FFF};
    vecs[3] = '{16'h1234, 0, 1'b1, 2'b10, 16'h1234};
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[4] = '{16'h0001, 1, 1'b0, 2'b11, 16'h8000};
`else
    vecs[4] = '{16'h0001, 1, 1'b0, 2'b11, 16'h0000};
`endif
    // vecs[0] releases reset at the same negedge it raises start: first edge accepts
    for (int i = 0; i < 5; i++)
      run_op(vecs[i].d, vecs[i].n, vecs[i].l, vecs[i].m, vecs[i].exp, 0, $sformatf("vec%0d", i));

    run_op(16'hAAAA, 8, 1'b0, 2'b00, 16'h00AA, 2, "start-while-busy");
    run_op(16'h5A5A, 3, 1'b1, 2'b00, 16'hD2D0, 4, "start-in-done");

    // reset mid-SHIFT abandons the operation
    @(negedge clk);
    din = 16'hAAAA; shamt = 4'd8; dir = 1'b0; mode = 2'b00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid-shift busy before reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset busy/done", {30'd0, busy, done}, 32'd0);
    check("async reset dout", 32'(dout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nodone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy) nodone++;
    end
    check("no done after reset release", 32'(nodone), 32'd0);
    check("dout stays zero after reset", 32'(dout), 32'd0);

    for (int k = 0; k < 40; k++) begin
      logic [15:0] d;
      int n;
      logic l;
      logic [1:0] m;
      d = 16'($urandom); n = $urandom_range(0, 15); l = 1'($urandom); m = 2'($urandom);
      run_op(d, n, l, m, model(d, n, l, m), 0, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
